// File: rtl/serial_cmp_ctrl_if.sv
// Handshake and result bundle for serial_cmp_ctrl: operands and cascade in,
// status and registered result flags out.
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cas_gt;
    logic             cas_lt;
    logic             cas_eq;
    logic             busy;
    logic             done;
    logic             res_gt;
    logic             res_lt;
    logic             res_eq;
    logic             err;

    modport master (
        output start, a, b, cas_gt, cas_lt, cas_eq,
        input  busy, done, res_gt, res_lt, res_eq, err
    );

    modport slave (
        input  start, a, b, cas_gt, cas_lt, cas_eq,
        output busy, done, res_gt, res_lt, res_eq, err
    );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude comparator: walks captured operands one nibble per cycle,
// MSB first, exits early on the first difference, else defers to the cascade.
module serial_cmp_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_cmp_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       cas_q;     // {gt, lt, eq}
    logic [IW-1:0]    idx_q;
    logic             done_q;
    logic [2:0]       res_q;     // {gt, lt, eq}
    logic             err_q;

    logic [3:0]       nib_a, nib_b;
    logic             nib_ne, last_nib, finish;

    assign nib_a    = 4'(a_q >> {idx_q, 2'b00});
    assign nib_b    = 4'(b_q >> {idx_q, 2'b00});
    assign nib_ne   = (nib_a != nib_b);
    assign last_nib = (idx_q == '0);
    assign finish   = nib_ne || last_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (finish)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy   = (state_q == RUN);
        bus.done   = done_q;
        bus.res_gt = res_q[2];
        bus.res_lt = res_q[1];
        bus.res_eq = res_q[0];
        bus.err    = err_q;
    end

    // Result registers only move on a finishing edge, never on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cas_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    a_q   <= bus.a;
                    b_q   <= bus.b;
                    cas_q <= {bus.cas_gt, bus.cas_lt, bus.cas_eq};
                    idx_q <= IW'(NIB - 1);
                end
            end else if (nib_ne) begin
                res_q  <= (nib_a > nib_b) ? 3'b100 : 3'b010;
                err_q  <= 1'b0;
                done_q <= 1'b1;
            end else if (!last_nib) begin
                idx_q <= idx_q - 1'b1;
            end else begin
                done_q <= 1'b1;
                case (cas_q)
                    3'b100, 3'b010, 3'b001: begin
                        res_q <= cas_q;
                        err_q <= 1'b0;
                    end
                    default: begin
                        res_q <= 3'b000;
                        err_q <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl (WIDTH=16): table vectors, hand-written corner
// sequences, and random operands checked against an arithmetic reference model.
module tb_serial_cmp_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   cas;   // {gt, lt, eq}
        logic [3:0]   exp;   // {gt, lt, eq, err}
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_tot  = 0;
    logic [3:0] prev_res = 4'b0000;

    serial_cmp_ctrl_if #(.WIDTH(W)) ifc ();

    serial_cmp_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_res();
        return {ifc.res_gt, ifc.res_lt, ifc.res_eq, ifc.err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: plain unsigned compare; latency from the highest differing nibble.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] cas);
        vec_t v;
        logic [W-1:0] d;
        v.a = a; v.b = b; v.cas = cas;
        d = a ^ b;
        v.lat = NIB;
        for (int i = 0; i < W; i++) if (d[i]) v.lat = NIB - i / 4;
        if (a > b)      v.exp = 4'b1000;
        else if (a < b) v.exp = 4'b0100;
        else if (cas == 3'b100 || cas == 3'b010 || cas == 3'b001) v.exp = {cas, 1'b0};
        else            v.exp = 4'b0001;
        return v;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] cas, input logic st);
        ifc.start  = st;
        ifc.a      = a;
        ifc.b      = b;
        {ifc.cas_gt, ifc.cas_lt, ifc.cas_eq} = cas;
    endtask

    // Entered at the negedge right after the accepting edge.
    task automatic wait_done(input vec_t v, input string nm, input bit disturb);
        int  lat = 0;
        bit  got = 0;
        chk({nm, "_busy_run"}, 32'(ifc.busy), 32'd1);
        chk({nm, "_hold_on_accept"}, 32'(dut_res()), 32'(prev_res));
        drive(W'($urandom), W'($urandom), 3'($urandom), disturb);
        while (!got && lat < NIB + 2) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ifc.done) got = 1;
            else drive(W'($urandom), W'($urandom), 3'($urandom), disturb && lat < 2);
        end
        ifc.start = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(v.lat));
        chk({nm, "_flags"}, 32'(dut_res()), 32'(v.exp));
        chk({nm, "_busy_at_done"}, 32'(ifc.busy), 32'd0);
        prev_res = v.exp;
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit disturb);
        @(negedge clk);
        drive(v.a, v.b, v.cas, 1'b1);
        @(posedge clk);
        @(negedge clk);
        wait_done(v, nm, disturb);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 32'(ifc.done), 32'd0);
        chk({nm, "_flags_hold"}, 32'(dut_res()), 32'(v.exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        drive('0, '0, 3'b000, 1'b0);

        tbl[0] = '{16'h8000, 16'h7FFF, 3'b001, 4'b1000, 1};
        tbl[1] = '{16'h1234, 16'h1235, 3'b001, 4'b0100, 4};
        tbl[2] = '{16'h12F0, 16'h1300, 3'b001, 4'b0100, 2};
        tbl[3] = '{16'hABCD, 16'hABCD, 3'b001, 4'b0010, 4};
        tbl[4] = '{16'hABCD, 16'hABCD, 3'b100, 4'b1000, 4};
        tbl[5] = '{16'hABCD, 16'hABCD, 3'b011, 4'b0001, 4};
        tbl[6] = '{16'hFFFF, 16'h0000, 3'b010, 4'b1000, 1};
        tbl[7] = '{16'h0000, 16'h0000, 3'b010, 4'b0100, 4};
        tbl[8] = '{16'hABCD, 16'hABCD, 3'b000, 4'b0001, 4};
        tbl[9] = '{16'h00A0, 16'h00A1, 3'b111, 4'b0100, 4};

        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_flags", 32'(dut_res()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i), 1'b0);

        // Mid-RUN start and operand changes must not disturb the captured compare.
        run_vec('{16'h1234, 16'h1234, 3'b100, 4'b1000, 4}, "midrun", 1'b1);

        // Back-to-back: start held in the done cycle is accepted on that edge.
        @(negedge clk);
        drive(16'h8000, 16'h7FFF, 3'b001, 1'b1);
        @(posedge clk);
        @(negedge clk);
        wait_done('{16'h8000, 16'h7FFF, 3'b001, 4'b1000, 1}, "b2b_first", 1'b0);
        drive(16'h0001, 16'h0002, 3'b001, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_done_drop", 32'(ifc.done), 32'd0);
        wait_done('{16'h0001, 16'h0002, 3'b001, 4'b0100, 4}, "b2b_second", 1'b0);

        // Reset in the second RUN cycle aborts with no done pulse.
        @(negedge clk);
        drive(16'h5555, 16'h5555, 3'b001, 1'b1);
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_flags", 32'(dut_res()), 32'd0);
        prev_res = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(ifc.done), 32'd0);
        end
        run_vec('{16'h0001, 16'h0000, 3'b001, 4'b1000, 4}, "after_rst", 1'b0);

        // Random operands: equal, single-nibble difference, or unrelated.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            int mode;
            ra = W'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0)      rb = ra;
            else if (mode == 1) rb = ra ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
            else                rb = W'($urandom);
            v = model(ra, rb, 3'($urandom));
            run_vec(v, $sformatf("rnd%0d", i), i % 3 == 0 && v.lat > 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be the operand width in bits; default 16; legal values are multiples of 4 with WIDTH >= 4; NIB = WIDTH/4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to compare; sampled on clk.
REQ-005 a  input  WIDTH  first operand; the result describes a relative to b.
REQ-006 b  input  WIDTH  second operand.
REQ-007 cas_gt, cas_lt, cas_eq  input  1 each  cascade inputs from a lower-order stage; used only when a == b.
REQ-008 busy  output  1  high while a comparison is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new valid result.
REQ-010 res_gt, res_lt, res_eq  output  1 each  registered result flags.
REQ-011 err  output  1  registered flag: the last result used an invalid cascade code.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and RUN; busy SHALL be 1 only in RUN.
REQ-013 In IDLE, start=1 SHALL be accepted on that edge: a, b, and the cascade inputs are captured into internal registers, the nibble index is set to NIB-1, and the FSM moves to RUN.
REQ-014 In RUN, start SHALL be ignored; changes on a, b, and cas_* after acceptance SHALL NOT affect the result.
REQ-015 Each RUN cycle SHALL compare exactly one captured 4-bit nibble pair, MSB nibble first, as unsigned values.
REQ-016 If the nibbles differ, that edge SHALL write res_gt/res_lt (exactly one set, res_eq=0, err=0), pulse done, and return to IDLE (early exit).
REQ-017 If the nibbles are equal and index > 0, the index SHALL decrement by 1 and the FSM stays in RUN.
REQ-018 If the nibbles are equal and index == 0, the captured cascade SHALL decide the result: {gt,lt,eq} = 100/010/001 gives the same flag set, err=0; any other code gives all flags 0 and err=1; done pulses and the FSM returns to IDLE.
REQ-019 Latency: done SHALL be high for exactly one cycle, following the m-th edge after the accepting edge, where m = number of nibbles examined (1..NIB).
REQ-020 done SHALL be high only while the FSM is in IDLE, so start asserted during the done cycle SHALL be accepted (back-to-back operation, no dead cycle).
REQ-021 res_* and err SHALL hold their values from a finishing edge until the next finishing edge; they SHALL NOT change on acceptance.
REQ-022 At most one of res_gt, res_lt, res_eq SHALL be 1 at any time.
REQ-023 The nibble index SHALL be ceil(log2(NIB)) bits wide, minimum 1, and SHALL never wrap below 0.

Reset
REQ-024 While rst_n=0, the block SHALL force IDLE, busy=0, done=0, res_gt=res_lt=res_eq=0, err=0, and nibble index=0, asynchronously.
REQ-025 Reset asserted during RUN SHALL abort the comparison with no done pulse; after release, the block SHALL accept the next start normally.

Verification (WIDTH=16)
REQ-026 a=16'h8000, b=16'h7FFF, start 1 cycle -> done 1 edge after acceptance, res_gt=1, res_lt=0, res_eq=0, busy high 1 cycle.
REQ-027 a=16'h1234, b=16'h1235 -> done after 4 edges, res_lt=1; a=16'h12F0, b=16'h1300 -> done after 2 edges, res_lt=1.
REQ-028 a=b=16'hABCD: with cas=001 -> res_eq=1 after 4 edges; repeat with cas=100 -> res_gt=1; repeat with cas=011 -> all flags 0 and err=1.
REQ-029 start and changed a/b applied mid-RUN -> ignored, and the result matches the originally captured operands; start held during the done cycle -> new comparison accepted on that edge.
REQ-030 rst_n pulsed low during the 2nd RUN cycle of a=b=16'h5555 -> no done pulse, all outputs 0; the next start with a=16'h0001, b=16'h0000 -> res_gt=1 after 4 edges.
